uart_tx_fifo: RTL

- Serial transmitter behind the core's memory-mapped UART TX data register (0x0000_1600).
- A store to 0x1600 presents a byte and a one-cycle write strobe; bytes are queued in a small FIFO and sent as 8N1 frames, LSB first.
- `tx_done` returns to the memory map as the status word at 0x0000_1604 and is high only when everything queued has left the line.

---
 rtl/uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-queued 8N1 serial transmitter behind a memory-mapped
// TX data register. Bytes written with tx_wr are held in a small FIFO and
// shifted out LSB first.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (frame becomes 8E1).
//
// Every output is registered from the current state, so the serial line
// follows the FSM state by one clock. For example, the start bit appears
// two edges after the edge that samples tx_wr.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  output logic       uart_txd,
  output logic       tx_done,
  output logic       tx_full,
  output logic       tx_ovf
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_wr_acc;
  logic          w_pop;

  // Transmit engine
  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  // Registered outputs
  logic          r_txd;
  logic          r_done;
  logic          r_full;
  logic          r_ovf;
  logic          w_txd_next;
  logic          w_done_next;

  // Writes are refused only when the queue is full; the FSM never blocks them.
  // A pop happens only from IDLE, whenever something is queued.
  assign w_wr_acc  = tx_wr & ~r_full;
  assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
  assign w_bit_end = (r_baud == BAUD_LAST);

  // Occupancy update: a simultaneous write and pop leaves the count unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_wr_acc, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage, pointers (wrap naturally at the power-of-two depth) and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_wr_acc) begin
        r_mem[r_wptr] <= tx_data;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic: each serial bit lasts until the baud counter wraps.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) w_state_next = ST_START;
        else       w_state_next = ST_IDLE;
      end
      ST_START: begin
        if (w_bit_end) w_state_next = ST_DATA;
        else           w_state_next = ST_START;
      end
      ST_DATA: begin
        if (w_bit_end && (r_bitcnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end else begin
          w_state_next = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_state_next = ST_STOP;
        else           w_state_next = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (w_bit_end) w_state_next = ST_IDLE;
        else           w_state_next = ST_STOP;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Baud counter, data-bit counter and shift register.
  // The baud counter clears on every state entry and at each data-bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud   <= '0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
`ifdef UART_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      if ((r_state == ST_IDLE) || (w_state_next != r_state) || w_bit_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + BW'(1);
      end

      if (r_state != ST_DATA) begin
        r_bitcnt <= 3'd0;
      end else if (w_bit_end) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end else begin
        r_bitcnt <= r_bitcnt;
      end

      if (w_pop) begin
        r_shift <= r_mem[r_rptr];
`ifdef UART_TX_PARITY_EN
        r_par   <= ^r_mem[r_rptr];
`endif
      end else if ((r_state == ST_DATA) && w_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  // FSM output logic: line level and done status derived from the current state.
  always_comb begin
    w_txd_next = 1'b1;
    case (r_state)
      ST_IDLE:   w_txd_next = 1'b1;
      ST_START:  w_txd_next = 1'b0;
      ST_DATA:   w_txd_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_txd_next = r_par;
`endif
      ST_STOP:   w_txd_next = 1'b1;
      default:   w_txd_next = 1'b1;
    endcase
    if ((r_state == ST_IDLE) && (r_count == '0)) begin
      w_done_next = 1'b1;
    end else begin
      w_done_next = 1'b0;
    end
  end

  // Output registers. tx_full tracks the count being loaded this edge.
  // tx_ovf flags a write that arrived while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txd  <= 1'b1;
      r_done <= 1'b1;
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_txd  <= w_txd_next;
      r_done <= w_done_next;
      r_full <= (w_count_next == COUNT_FULL);
      r_ovf  <= tx_wr & r_full;
    end
  end

  assign uart_txd = r_txd;
  assign tx_done  = r_done;
  assign tx_full  = r_full;
  assign tx_ovf   = r_ovf;

endmodule
